control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit that sequences the single-bus datapath (PC, IR, MAR, MDR, Y, Z, HI/LO, R0–R15, ALU) through fetch, decode and execute.
- Generates every register-in and bus-out strobe, the ALU op, and the memory Read/Write requests.
- Waits on a memory ready handshake and tracks retired instructions.
- Sits beside the datapath and drives its enables each cycle.

Parameters:
- WAIT_LIMIT, 255, maximum cycles a memory request may wait for mem_ready before a timeout halt (1–255).

Ports:
- clk  in  1  system clock, all state on the rising edge
- clr  in  1  synchronous active-low reset
- ir_op  in  5  opcode field IR[31:27] from the datapath
- mem_ready  in  1  memory done for the current Read/Write
- stop  in  1  external halt request
- pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out, pc_in, mdr_in, mdr_out, ir_in, y_in, hi_in, lo_in, c_out  out  1 each  datapath strobes
- gra, grb, grc, r_in, r_out  out  1 each  register-field select and general-register in/out
- alu_op  out  5  ALU operation
- read, write  out  1 each  memory requests
- run  out  1  high while executing
- t_step  out  4  current step (debug)
- instr_count  out  16  retired instruction counter
- err_illegal, err_timeout  out  1 each  sticky error flags

Behaviour:
- Reset: clr=0 at a clock edge moves the state to T0. It also clears instr_count, err_illegal, err_timeout and the wait counter, and drives all strobes, alu_op, read and write to 0, with run=1.
- Reset mid-instruction abandons the instruction. No pending read or write stays asserted.
- Strobe timing: strobes are Moore-decoded from state and ir_op. A strobe asserted in step Tn is captured by the datapath at the end of Tn.
- T0: pc_out, mar_in, inc_pc, z_in. If stop=1 in T0, go to HALT instead, with no strobes asserted.
- T1: zlow_out, pc_in, read, mdr_in. Hold T1 until mem_ready=1, then go to T2.
- T2: mdr_out, ir_in, then go to T3. Decode in T3 uses ir_op, which is valid from T3.
- R-type (00000 ADD, 00001 SUB, 00010 AND, 00011 OR):
  - T3: grb, r_out, y_in.
  - T4: grc, r_out, z_in, alu_op=ir_op.
  - T5: zlow_out, gra, r_in.
- MUL 01110 / DIV 01111:
  - T3: gra, r_out, y_in.
  - T4: grb, r_out, z_in, alu_op=ir_op.
  - T5: zlow_out, lo_in.
  - T6: zhigh_out, hi_in.
- ADDI 01000:
  - T3: grb, r_out, y_in.
  - T4: c_out, z_in, alu_op=00000.
  - T5: zlow_out, gra, r_in.
- LD 00100:
  - T3–T5: same as ADDI, except T5 drives zlow_out, mar_in.
  - T6: read, mdr_in, held until mem_ready.
  - T7: mdr_out, gra, r_in.
- ST 00101:
  - T3–T5: same as LD.
  - T6: gra, r_out, mdr_in (read=0 selects the bus).
  - T7: write, held until mem_ready.
- NOP 11010: T3 asserts nothing.
- HALT 11011: go to HALT.
- Illegal opcode (any other): executes as NOP and sets err_illegal.
- Retire: the last step of each instruction returns to T0 and increments instr_count. instr_count wraps 0xFFFF→0x0000. A HALT instruction does not increment it.
- HALT state: run=0 and all strobes 0. Exit only by reset.
- Wait counter:
  - Increments each cycle a read/write step is held with mem_ready=0.
  - Clears on leaving the step.
  - Reaching WAIT_LIMIT sets err_timeout and enters HALT with no strobes.
  - mem_ready=1 on the same cycle the limit is reached wins: the step completes normally.
- mem_ready outside a wait step is ignored.
- stop outside T0 is ignored; only the level seen in T0 matters.
- t_step encoding: T0–T7 → 0–7, HALT → 15.

Test Plan:
- Reset (clr=0 for 2 cycles), then ADD R1,R2,R3 (ir_op=00000) with mem_ready tied 1:
  - t_step goes 0,1,2,3,4,5,0.
  - T4 has alu_op=00000, grc, z_in; T5 has gra, r_in.
  - instr_count=1 after 6 cycles.
- LD with mem_ready low for 3 cycles in T1 and 2 cycles in T6:
  - read and mdr_in stay high for 4 and 3 cycles respectively.
  - Total 8+3+2=13 cycles; instr_count increments once.
- MUL (01110):
  - T5 asserts zlow_out+lo_in; T6 asserts zhigh_out+hi_in.
  - alu_op=01110 in T4; returns to T0 after T6.
- HALT opcode 11011:
  - run drops at T3+1 and t_step=15 persists with stop toggling.
  - instr_count unchanged.
  - clr=0 restores run=1 and t_step=0.
- WAIT_LIMIT=4, ST with mem_ready held 0 in T7: write high exactly 4 cycles, then err_timeout=1, run=0. Repeat with mem_ready=1 on the 4th wait cycle: normal retire, err_timeout=0.
- clr=0 during T4 of ST: next cycle all strobes 0 and t_step=0; write never asserts. Opcode 10111 afterwards: err_illegal=1 and instr_count increments.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus datapath: sequences fetch, decode
// and execute, handshakes with memory and counts retired instructions.
module control_sequencer #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  ir_op,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        pc_out,
  output logic        mar_in,
  output logic        inc_pc,
  output logic        z_in,
  output logic        zlow_out,
  output logic        zhigh_out,
  output logic        pc_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        y_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        c_out,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        r_in,
  output logic        r_out,
  output logic [4:0]  alu_op,
  output logic        read,
  output logic        write,
  output logic        run,
  output logic [3:0]  t_step,
  output logic [15:0] instr_count,
  output logic        err_illegal,
  output logic        err_timeout
);

  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
    T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
    HALT = 4'd15
  } stateT;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_LD   = 5'b00100;
  localparam logic [4:0] OP_ST   = 5'b00101;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  stateT      state, nextState, doneNext;
  logic [7:0] waitCnt, waitNext;
  logic       retire, doneRetire, setIllegal, setTimeout, memStep;
  logic       isRType, isMulDiv, isImm;

  assign isRType  = (ir_op == OP_ADD) || (ir_op == OP_SUB) ||
                    (ir_op == OP_AND) || (ir_op == OP_OR);
  assign isMulDiv = (ir_op == OP_MUL) || (ir_op == OP_DIV);
  assign isImm    = (ir_op == OP_ADDI) || (ir_op == OP_LD) || (ir_op == OP_ST);
  assign t_step   = state;
  assign run      = !clr || (state != HALT);

  always_ff @(posedge clk) begin
    if (!clr) begin
      state       <= T0;
      instrCountReset();
    end else begin
      state <= nextState;
      waitCnt <= waitNext;
      if (retire) instr_count <= instr_count + 16'd1;
      if (setIllegal) err_illegal <= 1'b1;
      if (setTimeout) err_timeout <= 1'b1;
    end
  end

  task automatic instrCountReset();
    instr_count <= 16'd0;
    err_illegal <= 1'b0;
    err_timeout <= 1'b0;
    waitCnt     <= 8'd0;
  endtask

  // Outputs stay at zero for the whole time clr is low, so an abandoned
  // instruction can never leave a memory request hanging.
  always_comb begin
    pc_out = 1'b0; mar_in = 1'b0; inc_pc = 1'b0; z_in = 1'b0;
    zlow_out = 1'b0; zhigh_out = 1'b0; pc_in = 1'b0; mdr_in = 1'b0;
    mdr_out = 1'b0; ir_in = 1'b0; y_in = 1'b0; hi_in = 1'b0; lo_in = 1'b0;
    c_out = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0;
    r_out = 1'b0; alu_op = 5'd0; read = 1'b0; write = 1'b0;
    nextState = state; doneNext = T0; doneRetire = 1'b0;
    retire = 1'b0; setIllegal = 1'b0; setTimeout = 1'b0;
    memStep = 1'b0; waitNext = 8'd0;
    if (clr) begin
      case (state)
        T0: begin
          if (stop) nextState = HALT;
          else begin
            pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
            nextState = T1;
          end
        end
        T1: begin
          zlow_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1;
          memStep = 1'b1; doneNext = T2;
        end
        T2: begin
          mdr_out = 1'b1; ir_in = 1'b1; nextState = T3;
        end
        T3: begin
          if (isRType || isImm) begin
            grb = 1'b1; r_out = 1'b1; y_in = 1'b1; nextState = T4;
          end else if (isMulDiv) begin
            gra = 1'b1; r_out = 1'b1; y_in = 1'b1; nextState = T4;
          end else if (ir_op == OP_HALT) nextState = HALT;
          else begin
            setIllegal = (ir_op != OP_NOP);
            retire = 1'b1; nextState = T0;
          end
        end
        T4: begin
          z_in = 1'b1; r_out = isRType || isMulDiv; nextState = T5;
          if (isRType) begin grc = 1'b1; alu_op = ir_op; end
          else if (isMulDiv) begin grb = 1'b1; alu_op = ir_op; end
          else c_out = 1'b1;
        end
        T5: begin
          zlow_out = 1'b1;
          if (isMulDiv) begin lo_in = 1'b1; nextState = T6; end
          else if (ir_op == OP_LD || ir_op == OP_ST) begin
            mar_in = 1'b1; nextState = T6;
          end else begin
            gra = 1'b1; r_in = 1'b1; retire = 1'b1; nextState = T0;
          end
        end
        T6: begin
          if (isMulDiv) begin
            zhigh_out = 1'b1; hi_in = 1'b1; retire = 1'b1; nextState = T0;
          end else if (ir_op == OP_LD) begin
            read = 1'b1; mdr_in = 1'b1; memStep = 1'b1; doneNext = T7;
          end else begin
            gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; nextState = T7;
          end
        end
        T7: begin
          if (ir_op == OP_ST) begin
            write = 1'b1; memStep = 1'b1; doneNext = T0; doneRetire = 1'b1;
          end else begin
            mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
            retire = 1'b1; nextState = T0;
          end
        end
        default: nextState = HALT;
      endcase
      // A ready on the limit cycle still completes the access.
      if (memStep) begin
        if (mem_ready) begin
          nextState = doneNext; retire = doneRetire;
        end else if (waitCnt >= LIMIT_M1) begin
          setTimeout = 1'b1; nextState = HALT;
        end else waitNext = waitCnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed per-cycle vectors push the
// expected outputs; a negedge monitor pops and compares them.
module tb_control_sequencer;

  logic clk = 1'b0, clr, memReady, stop;
  logic [4:0] irOp;
  logic pcOut, marIn, incPc, zIn, zlowOut, zhighOut, pcIn, mdrIn, mdrOut, irIn;
  logic yIn, hiIn, loIn, cOut, gra, grb, grc, rIn, rOut, read, write, run;
  logic errIllegal, errTimeout;
  logic [4:0]  aluOp;
  logic [3:0]  tStep;
  logic [15:0] instrCount;

  localparam logic [18:0] PCOUT = 19'h1 << 18, MARIN = 19'h1 << 17, INCPC = 19'h1 << 16;
  localparam logic [18:0] ZIN = 19'h1 << 15, ZLOW = 19'h1 << 14, ZHIGH = 19'h1 << 13;
  localparam logic [18:0] PCIN = 19'h1 << 12, MDRIN = 19'h1 << 11, MDROUT = 19'h1 << 10;
  localparam logic [18:0] IRIN = 19'h1 << 9, YIN = 19'h1 << 8, HIIN = 19'h1 << 7;
  localparam logic [18:0] LOIN = 19'h1 << 6, COUT = 19'h1 << 5, GRA = 19'h1 << 4;
  localparam logic [18:0] GRB = 19'h1 << 3, GRC = 19'h1 << 2, RIN = 19'h1 << 1, ROUT = 19'h1;

  typedef struct {
    string       name;
    logic [48:0] vec;
  } expT;

  expT expQ[$];
  int checks = 0, errors = 0;
  logic [15:0] cnt = 16'd0;
  logic ill = 1'b0, tmo = 1'b0;

  control_sequencer #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .clr(clr), .ir_op(irOp), .mem_ready(memReady), .stop(stop),
    .pc_out(pcOut), .mar_in(marIn), .inc_pc(incPc), .z_in(zIn),
    .zlow_out(zlowOut), .zhigh_out(zhighOut), .pc_in(pcIn), .mdr_in(mdrIn),
    .mdr_out(mdrOut), .ir_in(irIn), .y_in(yIn), .hi_in(hiIn), .lo_in(loIn),
    .c_out(cOut), .gra(gra), .grb(grb), .grc(grc), .r_in(rIn), .r_out(rOut),
    .alu_op(aluOp), .read(read), .write(write), .run(run), .t_step(tStep),
    .instr_count(instrCount), .err_illegal(errIllegal), .err_timeout(errTimeout)
  );

  always #5 clk = ~clk;

  // Monitor: every cycle that has an expectation queued is compared mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      expT e;
      logic [48:0] act;
      e = expQ.pop_front();
      act = {tStep, pcOut, marIn, incPc, zIn, zlowOut, zhighOut, pcIn, mdrIn,
             mdrOut, irIn, yIn, hiIn, loIn, cOut, gra, grb, grc, rIn, rOut,
             aluOp, read, write, run, instrCount, errIllegal, errTimeout};
      checks++;
      if (act !== e.vec) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.vec);
      end
    end
  end

  task automatic applyStimulus(input string nm, input logic c, input logic [4:0] op,
                               input logic mr, input logic st, input logic [3:0] stp,
                               input logic [18:0] sb, input logic [4:0] alu,
                               input logic rd, input logic wr, input logic rn);
    expT e;
    clr = c; irOp = op; memReady = mr; stop = st;
    e.name = nm;
    e.vec = {stp, sb, alu, rd, wr, rn, cnt, ill, tmo};
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [4:0] op, input int waits);
    applyStimulus("T0", 1, op, 1, 0, 0, PCOUT | MARIN | INCPC | ZIN, 0, 0, 0, 1);
    for (int i = 0; i < waits; i++)
      applyStimulus("T1wait", 1, op, 0, 0, 1, ZLOW | PCIN | MDRIN, 0, 1, 0, 1);
    applyStimulus("T1", 1, op, 1, 0, 1, ZLOW | PCIN | MDRIN, 0, 1, 0, 1);
    applyStimulus("T2", 1, op, 1, 0, 2, MDROUT | IRIN, 0, 0, 0, 1);
  endtask

  task automatic memPrefix(input logic [4:0] op);
    applyStimulus("memT3", 1, op, 1, 0, 3, GRB | ROUT | YIN, 0, 0, 0, 1);
    applyStimulus("memT4", 1, op, 1, 0, 4, COUT | ZIN, 0, 0, 0, 1);
    applyStimulus("memT5", 1, op, 1, 0, 5, ZLOW | MARIN, 0, 0, 0, 1);
  endtask

  task automatic checkOutput();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr = 0; irOp = 5'd0; memReady = 1; stop = 0;
    @(posedge clk); #1;
    applyStimulus("reset", 0, 5'd0, 1, 0, 0, 0, 0, 0, 0, 1);

    // ADD R1,R2,R3
    fetch(5'b00000, 0);
    applyStimulus("addT3", 1, 5'b00000, 1, 0, 3, GRB | ROUT | YIN, 0, 0, 0, 1);
    applyStimulus("addT4", 1, 5'b00000, 1, 0, 4, GRC | ROUT | ZIN, 5'b00000, 0, 0, 1);
    applyStimulus("addT5", 1, 5'b00000, 1, 0, 5, ZLOW | GRA | RIN, 0, 0, 0, 1);
    cnt = 1;

    // LD with 3 wait cycles in T1 and 2 in T6
    fetch(5'b00100, 3);
    memPrefix(5'b00100);
    applyStimulus("ldT6w", 1, 5'b00100, 0, 0, 6, MDRIN, 0, 1, 0, 1);
    applyStimulus("ldT6w", 1, 5'b00100, 0, 0, 6, MDRIN, 0, 1, 0, 1);
    applyStimulus("ldT6", 1, 5'b00100, 1, 0, 6, MDRIN, 0, 1, 0, 1);
    applyStimulus("ldT7", 1, 5'b00100, 1, 0, 7, MDROUT | GRA | RIN, 0, 0, 0, 1);
    cnt = 2;

    // MUL
    fetch(5'b01110, 0);
    applyStimulus("mulT3", 1, 5'b01110, 1, 0, 3, GRA | ROUT | YIN, 0, 0, 0, 1);
    applyStimulus("mulT4", 1, 5'b01110, 1, 0, 4, GRB | ROUT | ZIN, 5'b01110, 0, 0, 1);
    applyStimulus("mulT5", 1, 5'b01110, 1, 0, 5, ZLOW | LOIN, 0, 0, 0, 1);
    applyStimulus("mulT6", 1, 5'b01110, 1, 0, 6, ZHIGH | HIIN, 0, 0, 0, 1);
    cnt = 3;

    // ST, memory ready on the 4th wait cycle of T7 (limit cycle)
    fetch(5'b00101, 0);
    memPrefix(5'b00101);
    applyStimulus("stT6", 1, 5'b00101, 1, 0, 6, GRA | ROUT | MDRIN, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      applyStimulus("stT7w", 1, 5'b00101, 0, 0, 7, 0, 0, 0, 1, 1);
    applyStimulus("stT7last", 1, 5'b00101, 1, 0, 7, 0, 0, 0, 1, 1);
    cnt = 4;

    // ST abandoned by reset in T4
    fetch(5'b00101, 0);
    applyStimulus("stT3", 1, 5'b00101, 1, 0, 3, GRB | ROUT | YIN, 0, 0, 0, 1);
    applyStimulus("stT4rst", 0, 5'b00101, 1, 0, 4, 0, 0, 0, 0, 1);
    cnt = 0;
    applyStimulus("afterRst", 0, 5'b00101, 1, 0, 0, 0, 0, 0, 0, 1);

    // Illegal opcode, then NOP, then ADDI
    fetch(5'b10111, 0);
    applyStimulus("illT3", 1, 5'b10111, 1, 0, 3, 0, 0, 0, 0, 1);
    cnt = 1; ill = 1;
    fetch(5'b11010, 0);
    applyStimulus("nopT3", 1, 5'b11010, 1, 0, 3, 0, 0, 0, 0, 1);
    cnt = 2;
    fetch(5'b01000, 0);
    applyStimulus("addiT3", 1, 5'b01000, 1, 0, 3, GRB | ROUT | YIN, 0, 0, 0, 1);
    applyStimulus("addiT4", 1, 5'b01000, 1, 0, 4, COUT | ZIN, 0, 0, 0, 1);
    applyStimulus("addiT5", 1, 5'b01000, 1, 0, 5, ZLOW | GRA | RIN, 0, 0, 0, 1);
    cnt = 3;

    // ST timeout: write held exactly 4 cycles, then halt
    fetch(5'b00101, 0);
    memPrefix(5'b00101);
    applyStimulus("stT6", 1, 5'b00101, 1, 0, 6, GRA | ROUT | MDRIN, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      applyStimulus("toT7", 1, 5'b00101, 0, 0, 7, 0, 0, 0, 1, 1);
    tmo = 1;
    for (int i = 0; i < 4; i++)
      applyStimulus("toHalt", 1, 5'b00101, i[0], i[1], 15, 0, 0, 0, 0, 0);
    applyStimulus("haltRst", 0, 5'b00101, 1, 0, 15, 0, 0, 0, 0, 1);
    cnt = 0; ill = 0; tmo = 0;
    applyStimulus("haltRst2", 0, 5'b00101, 1, 0, 0, 0, 0, 0, 0, 1);

    // HALT opcode
    fetch(5'b11011, 0);
    applyStimulus("haltT3", 1, 5'b11011, 1, 0, 3, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      applyStimulus("haltOp", 1, 5'b11011, 1, i[0], 15, 0, 0, 0, 0, 0);
    applyStimulus("opRst", 0, 5'b11011, 1, 0, 15, 0, 0, 0, 0, 1);
    applyStimulus("opRst2", 0, 5'b11011, 1, 0, 0, 0, 0, 0, 0, 1);

    // stop seen in T0
    applyStimulus("T0stop", 1, 5'b00000, 1, 1, 0, 0, 0, 0, 0, 1);
    applyStimulus("stopHalt", 1, 5'b00000, 1, 0, 15, 0, 0, 0, 0, 0);

    @(negedge clk); #1;
    checkOutput();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
